// File: rtl/module_reg_pkg.sv
// Shared processor datapath constants for general-purpose registers.
// Imported by every datapath block that needs the bus width or the register clear value.
package module_reg_pkg;

    localparam int DATA_WIDTH = 8;

    localparam logic [DATA_WIDTH-1:0] REG_RESET_VALUE = 8'h00;

endpackage : module_reg_pkg

// File: rtl/module_reg.sv
// General-purpose processor register: bus load, self-increment and synchronous clear.
// Usable as a PC, address or counter register; contents are always visible on dout.
module module_reg
    import module_reg_pkg::*;
#(
    parameter int               WIDTH       = DATA_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(REG_RESET_VALUE)
) (
    input  logic             Clk,
    input  logic             RST,
    input  logic             Wen,
    input  logic             INC,
    input  logic [WIDTH-1:0] BusOut,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] reg_r;

    // Register update: clear beats load, and load beats increment (wraps modulo 2^WIDTH).
    always_ff @(posedge Clk) begin
        if (RST) begin
            reg_r <= RESET_VALUE;
        end else if (Wen) begin
            reg_r <= BusOut;
        end else if (INC) begin
            reg_r <= reg_r + WIDTH'(1);
        end else begin
            reg_r <= reg_r;
        end
    end

    assign dout = reg_r;

endmodule : module_reg

// File: tb/tb_module_reg.sv
// Self-checking bench for module_reg: directed scenarios, then randomized traffic
// compared every edge against an arithmetic reference model.
module tb_module_reg;

    localparam int W = 8;

    logic         Clk;
    logic         RST;
    logic         Wen;
    logic         INC;
    logic [W-1:0] BusOut;
    logic [W-1:0] dout;

    int checks;
    int errors;
    int model;

    module_reg dut (
        .Clk    (Clk),
        .RST    (RST),
        .Wen    (Wen),
        .INC    (INC),
        .BusOut (BusOut),
        .dout   (dout)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Apply one cycle of controls, let the edge happen, update the model and compare.
    task automatic step(input string tag, input logic rst, input logic wen,
                        input logic inc, input logic [W-1:0] bus);
        logic [W-1:0] expv;
        RST    = rst;
        Wen    = wen;
        INC    = inc;
        BusOut = bus;
        @(posedge Clk);
        #1;
        if (rst)      model = 0;
        else if (wen) model = int'(bus);
        else if (inc) model = (model + 1) % 256;
        expv = W'(model);
        checks++;
        assert (dout === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, dout, expv);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model  = 0;
        RST    = 1'b0;
        Wen    = 1'b0;
        INC    = 1'b0;
        BusOut = 8'h00;
        @(negedge Clk);

        step("reset",          1'b1, 1'b0, 1'b0, 8'h00);
        step("load12",         1'b0, 1'b1, 1'b0, 8'd12);
        for (int i = 0; i < 3; i++)
            step("hold12",     1'b0, 1'b0, 1'b0, 8'd99);
        for (int i = 0; i < 4; i++)
            step("inc",        1'b0, 1'b0, 1'b1, 8'd77);
        step("load13",         1'b0, 1'b1, 1'b0, 8'd13);
        step("rst_clear",      1'b1, 1'b0, 1'b0, 8'd0);
        step("rst_over_wen",   1'b1, 1'b1, 1'b1, 8'd32);
        step("wen_after_rst",  1'b0, 1'b1, 1'b0, 8'd32);
        step("loadFF",         1'b0, 1'b1, 1'b0, 8'hFF);
        step("wrap00",         1'b0, 1'b0, 1'b1, 8'h00);
        step("wrap01",         1'b0, 1'b0, 1'b1, 8'h00);
        step("load5",          1'b0, 1'b1, 1'b0, 8'd5);
        step("wen_beats_inc",  1'b0, 1'b1, 1'b1, 8'd40);
        step("inc_after",      1'b0, 1'b0, 1'b1, 8'd0);

        for (int i = 0; i < 60; i++) begin
            step("random",
                 ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0,
                 W'($urandom_range(0, 255)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_module_reg

// File: doc/module_reg.md
Name: module_reg

Overview:
- General-purpose 8-bit processor register with load-from-bus, increment and synchronous clear.
- Sits on the datapath. It captures the main bus value (BusOut) on a write enable.
- Can self-increment, for use as a PC, address or counter register.
- Continuously drives its contents on dout.

Parameters:
- WIDTH, 8, data width of bus input and register output.
- RESET_VALUE, 0, value loaded when RST is sampled high.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-high reset/clear.
- Wen  input  1  write enable; load BusOut on the next rising edge.
- INC  input  1  increment enable; add 1 to the register on the next rising edge.
- BusOut  input  WIDTH  data from the processor bus.
- dout  output  WIDTH  current register contents.

Behaviour:
- Single register, reg_q[WIDTH-1:0], updated only on posedge Clk. dout = reg_q combinationally (no extra output stage).
- Priority per rising edge, highest first:
  - RST=1 -> reg_q <= RESET_VALUE.
  - else Wen=1 -> reg_q <= BusOut.
  - else INC=1 -> reg_q <= reg_q + 1.
  - else hold.
- Reset is synchronous. Asserting RST between edges has no effect until the next rising edge. Deasserting RST resumes normal operation on the following edge.
- RST=1 overrides simultaneous Wen and/or INC. The bus value and the increment are both discarded.
- Wen=1 and INC=1 together: load BusOut only. No increment is applied to the loaded value.
- Increment is modulo 2^WIDTH: 8'hFF + 1 -> 8'h00. There is no carry or overflow output.
- Latency: one cycle. A value loaded or incremented at edge N is visible on dout immediately after edge N.
- Before the first RST or Wen the contents are unspecified. Verification must not check dout before the first reset or write.
- All control inputs are treated as synchronous to Clk. No internal synchronisers.
- No read enable; dout is always valid. Bus tristating is the bus multiplexer's job, not this block's.

Decomposition:
- Shared processor package holds DATA_WIDTH = 8 (default for WIDTH) and the register reset constant.
- No sub-module: a single always_ff block with a priority if/else chain. The incrementer is a plain "+1" within the block.

Test Plan:
- Load: BusOut=12, Wen=1 for one edge -> dout=12 after that edge. Wen=0, INC=0 for 3 edges -> dout holds 12.
- Increment: from dout=12, INC=1 for one edge -> dout=13. Hold INC=1 for 3 more edges -> 14, 15, 16.
- Reset priority: from dout=13, RST=1 -> dout=0. Next edge with RST=1, Wen=1, BusOut=32 -> dout stays 0. Drop RST with Wen=1, BusOut=32 -> dout=32.
- Wrap-around: load 8'hFF, INC=1 -> dout=8'h00, then INC=1 -> 8'h01.
- Load beats increment: dout=5, Wen=1 and INC=1 with BusOut=40 -> dout=40, not 41.
- Randomized: 10+ cycles of random BusOut/Wen/INC/RST, checked every edge against a reference model implementing the priority RST > Wen > INC > hold, with mod-256 increment.
